// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter sharing one FPU among NUM_REQ requesters: IDLE -> ISSUE -> WAIT -> RESP.
// Optional WAIT-state abort is enabled by defining FP_ARB_TIMEOUT_EN.
module fp_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [OP_W-1:0]           fpu_op_type,
    output logic [DATA_W-1:0]         fpu_dataa,
    output logic [DATA_W-1:0]         fpu_datab,
    output logic                      fpu_start,
    input  logic                      fpu_done,
    input  logic [DATA_W-1:0]         fpu_result
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("fp_op_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rr_ptr, idx, sel_idx;
    logic               sel_vld;
    logic               to_hit;
    logic [IDX_W:0]     pos;

    // Walk offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        pos     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_REQ))
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            if (req[pos[IDX_W-1:0]]) begin
                sel_idx = pos[IDX_W-1:0];
                sel_vld = 1'b1;
            end
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign to_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state == ISSUE)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel_vld) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (fpu_done || to_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            idx         <= '0;
            grant       <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            fpu_op_type <= '0;
            fpu_dataa   <= '0;
            fpu_datab   <= '0;
            fpu_start   <= 1'b0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != IDLE);
            grant     <= '0;
            fpu_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (sel_vld) begin
                    idx         <= sel_idx;
                    fpu_op_type <= req_op[sel_idx*OP_W +: OP_W];
                    fpu_dataa   <= req_a[sel_idx*DATA_W +: DATA_W];
                    fpu_datab   <= req_b[sel_idx*DATA_W +: DATA_W];
                    grant       <= NUM_REQ'(1) << sel_idx;
                    fpu_start   <= 1'b1;
                end
                WAIT: if (fpu_done) begin
                    rsp_data  <= fpu_result;
                    rsp_err   <= 1'b0;
                    rsp_valid <= NUM_REQ'(1) << idx;
                end else if (to_hit) begin
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= NUM_REQ'(1) << idx;
                end
                RESP: rr_ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_op_arbiter.sv
// Directed + randomized bench for fp_op_arbiter; a queue-free round-robin model picks the expected winner.
module tb_fp_op_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*OW-1:0] req_op;
    logic [N*DW-1:0] req_a, req_b;
    logic [N-1:0]    grant, rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err, busy;
    logic [OW-1:0]   fpu_op_type;
    logic [DW-1:0]   fpu_dataa, fpu_datab;
    logic            fpu_start;
    logic            fpu_done;
    logic [DW-1:0]   fpu_result;

    int errors = 0;
    int checks = 0;
    int model_rr = 0;

    fp_op_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .fpu_op_type(fpu_op_type), .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab),
        .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_result(fpu_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first set bit at or after the round-robin pointer, wrapping.
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(model_rr + k) % N]) return (model_rr + k) % N;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_op[i*OW +: OW] = OW'($urandom);
            req_a[i*DW +: DW]  = $urandom;
            req_b[i*DW +: DW]  = $urandom;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_op"}, fpu_op_type, 0);
        chk({tag, "_a"}, fpu_dataa, 0);
        chk({tag, "_b"}, fpu_datab, 0);
        chk({tag, "_start"}, fpu_start, 0);
    endtask

    // Called at an IDLE sample point with req nonzero; returns at the following IDLE sample point.
    task automatic run_op(input int lat, input bit hold, input bit spur, input logic [DW-1:0] res);
        int w;
        logic [OW-1:0] eop;
        logic [DW-1:0] ea, eb;
        w = pick(req);
        if (w < 0) begin
            chk("run_op_no_req", 1, 0);
            return;
        end
        eop = req_op[w*OW +: OW];
        ea  = req_a[w*DW +: DW];
        eb  = req_b[w*DW +: DW];
        step();
        chk("issue_grant", grant, 64'(1) << w);
        chk("issue_start", fpu_start, 1);
        chk("issue_op", fpu_op_type, eop);
        chk("issue_a", fpu_dataa, ea);
        chk("issue_b", fpu_datab, eb);
        chk("issue_busy", busy, 1);
        chk("issue_rsp_valid", rsp_valid, 0);
        if (!hold) req[w] = 1'b0;
        fpu_done = spur;
        step();
        fpu_done = 1'b0;
        chk("wait_grant", grant, 0);
        chk("wait_start", fpu_start, 0);
        chk("wait_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < lat - 1; i++) begin
            step();
            chk("wait_busy", busy, 1);
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_a_stable", fpu_dataa, ea);
            chk("wait_b_stable", fpu_datab, eb);
        end
        fpu_result = res;
        fpu_done   = 1'b1;
        step();
        fpu_done   = 1'b0;
        fpu_result = $urandom;
        chk("resp_valid", rsp_valid, 64'(1) << w);
        chk("resp_data", rsp_data, res);
        chk("resp_err", rsp_err, 0);
        chk("resp_busy", busy, 1);
        model_rr = (w + 1) % N;
        step();
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data_hold", rsp_data, res);
        chk("idle_op_hold", fpu_op_type, eop);
    endtask

    initial begin
        int w;
        reset_n = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0;
        fpu_done = 1'b0; fpu_result = '0;
        step(); step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();
        chk("post_reset_busy", busy, 0);

        // Contention: all four held, unit latency -> 0,1,2,3,0
        rand_ops();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_op(1, 1'b1, 1'b0, $urandom);
        req = '0;

        // Single request with the reference operands
        req_op[0 +: OW] = 8'h02;
        req_a[0 +: DW]  = 32'h3F80_0000;
        req_b[0 +: DW]  = 32'h4000_0000;
        req = 4'b0001;
        run_op(3, 1'b0, 1'b0, 32'h4040_0000);

        // Walk pointer to 3, then 1001 must serve 3 before 0
        req = 4'b0010; run_op(1, 1'b0, 1'b0, $urandom);
        req = 4'b0100; run_op(2, 1'b0, 1'b0, $urandom);
        req = 4'b1001; run_op(1, 1'b0, 1'b0, $urandom);
        chk("wrap_pending", req, 4'b0001);
        run_op(1, 1'b0, 1'b0, $urandom);

        // Spurious done in IDLE and during ISSUE
        fpu_done = 1'b1;
        step(); chk("spur_idle_rsp", rsp_valid, 0); chk("spur_idle_busy", busy, 0);
        step(); chk("spur_idle_rsp2", rsp_valid, 0);
        fpu_done = 1'b0;
        req = 4'b0100;
        run_op(2, 1'b0, 1'b1, $urandom);

        // Reset during WAIT, late done ignored, pointer back to 0
        rand_ops();
        req = 4'b0010;
        step();
        chk("rst_issue_grant", grant, 4'b0010);
        req = '0;
        step(); step();
        chk("rst_wait_busy", busy, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk_all_zero("midop_reset");
        model_rr = 0;
        fpu_result = 32'hDEAD_BEEF;
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("late_done_rsp", rsp_valid, 0);
        chk("late_done_busy", busy, 0);
        req = 4'b1111;
        w = pick(req);
        chk("rst_model_ptr", w, 0);
        run_op(1, 1'b0, 1'b0, $urandom);
        req = '0;

        // FPU never answers
        rand_ops();
        req = 4'b0001;
        w = pick(req);
        step();
        chk("to_grant", grant, 64'(1) << w);
        req = '0;
        step();
`ifdef FP_ARB_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            step();
            chk("to_wait_rsp", rsp_valid, 0);
        end
        step();
        chk("to_rsp_valid", rsp_valid, 64'(1) << w);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_data", rsp_data, 0);
        model_rr = (w + 1) % N;
        step();
        chk("to_idle_busy", busy, 0);
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("to_late_done", rsp_valid, 0);
`else
        for (int i = 0; i < 3 * TO; i++) begin
            step();
            chk("noto_busy", busy, 1);
            chk("noto_rsp", rsp_valid, 0);
        end
        fpu_result = 32'h1234_5678;
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("noto_rsp_valid", rsp_valid, 64'(1) << w);
        chk("noto_rsp_data", rsp_data, 32'h1234_5678);
        chk("noto_rsp_err", rsp_err, 0);
        model_rr = (w + 1) % N;
        step();
        chk("noto_idle_busy", busy, 0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            req = req | N'($urandom_range(1, (1 << N) - 1));
            run_op(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
